// File: rtl/pipe_hold_ctrl_if.sv
// Handshake bundle between execute/arbiter/CLINT/JTAG sources and the pipeline hold controller.
// The master side drives the requests; the slave side (the controller) drives hold and redirect.
interface pipe_hold_ctrl_if;
   logic        jump_flag_i;
   logic [31:0] jump_addr_i;
   logic        hold_ex_i;
   logic        hold_rib_i;
   logic        hold_clint_i;
   logic        halt_req_i;
   logic [2:0]  hold_flag_o;
   logic        jump_flag_o;
   logic [31:0] jump_addr_o;
   logic        halt_ack_o;

   modport master (
      output jump_flag_i, jump_addr_i, hold_ex_i, hold_rib_i, hold_clint_i, halt_req_i,
      input  hold_flag_o, jump_flag_o, jump_addr_o, halt_ack_o
   );

   modport slave (
      input  jump_flag_i, jump_addr_i, hold_ex_i, hold_rib_i, hold_clint_i, halt_req_i,
      output hold_flag_o, jump_flag_o, jump_addr_o, halt_ack_o
   );
endinterface

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold controller: priority-merges stall sources into one hold level, forwards the
// jump redirect, and sequences post-jump flush and debug halt/drain.
module pipe_hold_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic           clk,
   input  logic           rst,
   pipe_hold_ctrl_if.slave bus
);

   localparam logic [2:0] HOLD_NONE  = 3'd0;
   localparam logic [2:0] HOLD_PC    = 3'd1;
   localparam logic [2:0] HOLD_ID    = 3'd3;
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_FLUSH,
      ST_DRAIN,
      ST_HALTED
   } state_t;

   state_t      r_state;
   logic [2:0]  r_cnt;
   logic        r_halt_ack;

   logic        w_hold_id;
   logic        w_hold_pc;
   logic [2:0]  w_hold_flag;
   logic        w_jump_flag;
   logic [31:0] w_jump_addr;

   // halt_ack is set on the edge entering HALTED and cleared on the edge leaving it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_RUN;
         r_cnt      <= 3'd0;
         r_halt_ack <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (bus.jump_flag_i) begin
                  r_state <= ST_FLUSH;
                  r_cnt   <= FLUSH_LOAD;
               end else if (bus.halt_req_i) begin
                  r_state <= ST_DRAIN;
                  r_cnt   <= DRAIN_LOAD;
               end
            end
            ST_FLUSH: begin
               if (bus.jump_flag_i) begin
                  r_cnt <= FLUSH_LOAD;
               end else if (r_cnt != 3'd0) begin
                  r_cnt <= r_cnt - 3'd1;
               end else if (bus.halt_req_i) begin
                  r_state <= ST_DRAIN;
                  r_cnt   <= DRAIN_LOAD;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (bus.jump_flag_i) begin
                  r_state <= ST_FLUSH;
                  r_cnt   <= FLUSH_LOAD;
               end else if (!bus.halt_req_i) begin
                  r_state <= ST_RUN;
               end else if (bus.hold_ex_i) begin
                  r_cnt <= DRAIN_LOAD;
               end else if (r_cnt != 3'd0) begin
                  r_cnt <= r_cnt - 3'd1;
               end else begin
                  r_state    <= ST_HALTED;
                  r_halt_ack <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (!bus.halt_req_i) begin
                  r_state    <= ST_RUN;
                  r_halt_ack <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_RUN;
               r_halt_ack <= 1'b0;
            end
         endcase
      end
   end

   // Hold_Id dominates Hold_Pc, so "maximum level" reduces to a two-tier priority.
   always_comb begin
      w_hold_id   = bus.jump_flag_i | bus.hold_ex_i | bus.hold_clint_i
                  | (r_state == ST_FLUSH) | (r_state == ST_HALTED);
      w_hold_pc   = bus.hold_rib_i | (r_state == ST_DRAIN);
      w_hold_flag = HOLD_NONE;
      w_jump_flag = 1'b0;
      w_jump_addr = 32'd0;
      if (rst) begin
         if (w_hold_id) begin
            w_hold_flag = HOLD_ID;
         end else if (w_hold_pc) begin
            w_hold_flag = HOLD_PC;
         end
         w_jump_flag = bus.jump_flag_i;
         w_jump_addr = bus.jump_flag_i ? bus.jump_addr_i : 32'd0;
      end
   end

   assign bus.hold_flag_o = w_hold_flag;
   assign bus.jump_flag_o = w_jump_flag;
   assign bus.jump_addr_o = w_jump_addr;
   assign bus.halt_ack_o  = r_halt_ack;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Directed bench for pipe_hold_ctrl with FLUSH_CYCLES=2, DRAIN_CYCLES=3.
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
module tb_pipe_hold_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   pipe_hold_ctrl_if bus();

   pipe_hold_ctrl #(
      .FLUSH_CYCLES (2),
      .DRAIN_CYCLES (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.jump_flag_i  = 1'b0;
      bus.jump_addr_i  = 32'd0;
      bus.hold_ex_i    = 1'b0;
      bus.hold_rib_i   = 1'b0;
      bus.hold_clint_i = 1'b0;
      bus.halt_req_i   = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      bus.jump_flag_i = 1'b1;
      bus.jump_addr_i = 32'hDEAD_BEEF;
      bus.hold_ex_i   = 1'b1;
      #1;
      n_checks++;
      if (bus.hold_flag_o !== 3'd0) begin
         n_errors++; $display("FAIL reset_hold: got %0d expected 0", bus.hold_flag_o);
      end
      n_checks++;
      if (bus.jump_flag_o !== 1'b0) begin
         n_errors++; $display("FAIL reset_jump_flag: got %0b expected 0", bus.jump_flag_o);
      end
      n_checks++;
      if (bus.jump_addr_o !== 32'd0) begin
         n_errors++; $display("FAIL reset_jump_addr: got %08h expected 00000000", bus.jump_addr_o);
      end
      n_checks++;
      if (bus.halt_ack_o !== 1'b0) begin
         n_errors++; $display("FAIL reset_ack: got %0b expected 0", bus.halt_ack_o);
      end
      clear_inputs();
      @(posedge clk);
      #2 rst = 1'b1;
      step();
      #1;
      n_checks++;
      if (bus.hold_flag_o !== 3'd0 || bus.halt_ack_o !== 1'b0) begin
         n_errors++;
         $display("FAIL post_reset: got hold=%0d ack=%0b expected hold=0 ack=0",
                  bus.hold_flag_o, bus.halt_ack_o);
      end
      $display("test_reset done: hold=%0d ack=%0b", bus.hold_flag_o, bus.halt_ack_o);
   endtask

   task automatic test_jump_flush();
      int jf[4]     = '{1, 0, 0, 0};
      int hold_e[4] = '{3, 3, 3, 0};
      for (int k = 0; k < 4; k++) begin
         step();
         bus.jump_flag_i = jf[k][0];
         bus.jump_addr_i = 32'h0000_0100;
         #1;
         n_checks++;
         if (bus.hold_flag_o !== 3'(hold_e[k])) begin
            n_errors++;
            $display("FAIL flush_hold[%0d]: got %0d expected %0d", k, bus.hold_flag_o, hold_e[k]);
         end
         n_checks++;
         if (bus.jump_flag_o !== jf[k][0] ||
             bus.jump_addr_o !== (jf[k][0] ? 32'h0000_0100 : 32'd0)) begin
            n_errors++;
            $display("FAIL flush_redirect[%0d]: got flag=%0b addr=%08h expected flag=%0b addr=%08h",
                     k, bus.jump_flag_o, bus.jump_addr_o, jf[k][0],
                     (jf[k][0] ? 32'h0000_0100 : 32'd0));
         end
         $display("jump_flush cyc %0d: jf=%0b hold=%0d addr=%08h", k, jf[k][0],
                  bus.hold_flag_o, bus.jump_addr_o);
      end
      clear_inputs();
   endtask

   task automatic test_rib_ex();
      int rib[6]    = '{1, 1, 1, 0, 0, 0};
      int ex[6]     = '{1, 0, 0, 0, 0, 0};
      int clint[6]  = '{0, 0, 0, 0, 1, 0};
      int hold_e[6] = '{3, 1, 1, 0, 3, 0};
      for (int k = 0; k < 6; k++) begin
         step();
         bus.hold_rib_i   = rib[k][0];
         bus.hold_ex_i    = ex[k][0];
         bus.hold_clint_i = clint[k][0];
         #1;
         n_checks++;
         if (bus.hold_flag_o !== 3'(hold_e[k])) begin
            n_errors++;
            $display("FAIL rib_ex_hold[%0d]: got %0d expected %0d", k, bus.hold_flag_o, hold_e[k]);
         end
         $display("rib_ex cyc %0d: rib=%0b ex=%0b clint=%0b hold=%0d", k, rib[k][0], ex[k][0],
                  clint[k][0], bus.hold_flag_o);
      end
      clear_inputs();
   endtask

   task automatic test_halt_drain();
      int halt[10]   = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
      int ex[10]     = '{0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
      int jf[10]     = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
      int hold_e[10] = '{0, 3, 3, 1, 1, 1, 3, 3, 3, 0};
      int ack_e[10]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
      for (int k = 0; k < 10; k++) begin
         step();
         bus.halt_req_i  = halt[k][0];
         bus.hold_ex_i   = ex[k][0];
         bus.jump_flag_i = jf[k][0];
         bus.jump_addr_i = 32'h0000_0200;
         #1;
         n_checks++;
         if (bus.hold_flag_o !== 3'(hold_e[k]) || bus.halt_ack_o !== ack_e[k][0]) begin
            n_errors++;
            $display("FAIL drain[%0d]: got hold=%0d ack=%0b expected hold=%0d ack=%0b",
                     k, bus.hold_flag_o, bus.halt_ack_o, hold_e[k], ack_e[k][0]);
         end
         if (jf[k] != 0) begin
            n_checks++;
            if (bus.jump_flag_o !== 1'b1 || bus.jump_addr_o !== 32'h0000_0200) begin
               n_errors++;
               $display("FAIL halted_redirect: got flag=%0b addr=%08h expected flag=1 addr=00000200",
                        bus.jump_flag_o, bus.jump_addr_o);
            end
         end
         $display("halt_drain cyc %0d: halt=%0b ex=%0b jf=%0b hold=%0d ack=%0b", k, halt[k][0],
                  ex[k][0], jf[k][0], bus.hold_flag_o, bus.halt_ack_o);
      end
      clear_inputs();
   endtask

   task automatic test_jump_halt();
      int halt[9]   = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
      int jf[9]     = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
      int hold_e[9] = '{3, 3, 3, 1, 1, 1, 3, 3, 0};
      int ack_e[9]  = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
      for (int k = 0; k < 9; k++) begin
         step();
         bus.halt_req_i  = halt[k][0];
         bus.jump_flag_i = jf[k][0];
         bus.jump_addr_i = 32'h0000_0400;
         #1;
         n_checks++;
         if (bus.hold_flag_o !== 3'(hold_e[k]) || bus.halt_ack_o !== ack_e[k][0]) begin
            n_errors++;
            $display("FAIL jump_halt[%0d]: got hold=%0d ack=%0b expected hold=%0d ack=%0b",
                     k, bus.hold_flag_o, bus.halt_ack_o, hold_e[k], ack_e[k][0]);
         end
         $display("jump_halt cyc %0d: halt=%0b jf=%0b hold=%0d ack=%0b", k, halt[k][0], jf[k][0],
                  bus.hold_flag_o, bus.halt_ack_o);
      end
      clear_inputs();
   endtask

   task automatic test_drain_abort();
      int halt[5]   = '{1, 1, 0, 0, 0};
      int hold_e[5] = '{0, 1, 1, 0, 0};
      for (int k = 0; k < 5; k++) begin
         step();
         bus.halt_req_i = halt[k][0];
         #1;
         n_checks++;
         if (bus.hold_flag_o !== 3'(hold_e[k]) || bus.halt_ack_o !== 1'b0) begin
            n_errors++;
            $display("FAIL drain_abort[%0d]: got hold=%0d ack=%0b expected hold=%0d ack=0",
                     k, bus.hold_flag_o, bus.halt_ack_o, hold_e[k]);
         end
         $display("drain_abort cyc %0d: halt=%0b hold=%0d ack=%0b", k, halt[k][0],
                  bus.hold_flag_o, bus.halt_ack_o);
      end
      clear_inputs();
   endtask

   task automatic test_async_reset();
      bit reached = 1'b0;
      step();
      bus.halt_req_i = 1'b1;
      for (int k = 0; k < 20 && !reached; k++) begin
         step();
         #1;
         reached = bus.halt_ack_o;
      end
      n_checks++;
      if (!reached) begin
         n_errors++; $display("FAIL halt_timeout: got ack=0 expected ack=1 within 20 cycles");
      end
      #1;
      rst = 1'b0;
      bus.halt_req_i = 1'b0;
      #1;
      n_checks++;
      if (bus.halt_ack_o !== 1'b0 || bus.hold_flag_o !== 3'd0) begin
         n_errors++;
         $display("FAIL async_reset: got ack=%0b hold=%0d expected ack=0 hold=0",
                  bus.halt_ack_o, bus.hold_flag_o);
      end
      @(negedge clk);
      rst = 1'b1;
      step();
      #1;
      n_checks++;
      if (bus.halt_ack_o !== 1'b0 || bus.hold_flag_o !== 3'd0) begin
         n_errors++;
         $display("FAIL after_async_reset: got ack=%0b hold=%0d expected ack=0 hold=0",
                  bus.halt_ack_o, bus.hold_flag_o);
      end
      $display("async_reset done: ack=%0b hold=%0d", bus.halt_ack_o, bus.hold_flag_o);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b0;
      clear_inputs();
      test_reset();
      test_jump_flush();
      test_rib_ex();
      test_halt_drain();
      test_jump_halt();
      test_drain_abort();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
